// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared state and mode encodings for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/addsub_cell.sv
// addsub_cell: combinational 1-bit full adder (mode=0) / full subtractor (mode=1)
module addsub_cell
  import serial_addsub_pkg::*;
(
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic mode,
  output logic s,
  output logic cout_bit
);
  assign s = x ^ y ^ cin;
  assign cout_bit = (mode == MODE_SUB) ? ((~x & y) | (~x & cin) | (y & cin))
                                       : ((x & y) | (x & cin) | (y & cin));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: LSB-first bit-serial add/sub, one bit per clock through a single cell.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, mode_q, busy_q, done_q, cout_q;
  logic             s_d, c_d;
  addsub_cell u_cell (
    .x       (a_q[0]),
    .y       (b_q[0]),
    .cin     (c_q),
    .mode    (mode_q),
    .s       (s_d),
    .cout_bit(c_d)
  );
`ifdef SERIAL_ADDSUB_OVF_EN
  logic am_q, bm_q, ovf_q, ovf_d;
  // the last bit processed is the result MSB, so s_d is the sign of the result here
  assign ovf_d = ((am_q ^ bm_q) == mode_q) & (s_d ^ am_q);
  assign ovf   = ovf_q;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      mode_q  <= MODE_ADD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= mode;
            c_q     <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
`ifdef SERIAL_ADDSUB_OVF_EN
            am_q    <= a[WIDTH-1];
            bm_q    <= b[WIDTH-1];
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          res_q <= {s_d, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            cout_q  <= c_d;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = res_q;
  assign cout   = cout_q;
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: directed test-plan cases plus random traffic against an arithmetic model
module tb_serial_addsub;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [W-1:0] a = '0, b = '0, result;
  logic busy, done, cout, ovf_s;
  int total = 0, bad = 0, dcount = 0;
  bit chk_en = 0;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf;
  assign ovf_s = ovf;
`else
  assign ovf_s = 1'b0;
`endif
  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mode  (mode),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
`ifdef SERIAL_ADDSUB_OVF_EN
    .ovf   (ovf),
`endif
    .cout  (cout)
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // model: operation outcome from plain integer arithmetic, timing as a countdown of cycles
  bit m_busy, m_done, m_cout, m_ovf, p_cout, p_ovf;
  int m_left, m_res, p_res;
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_res = 0; m_cout = 0; m_ovf = 0; m_left = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1; m_res = p_res; m_cout = p_cout; m_ovf = p_ovf;
        end
      end else if (start) begin
        int ua, ub, sa, sb, sr;
        ua = int'(a); ub = int'(b);
        sa = ua >= 128 ? ua - 256 : ua;
        sb = ub >= 128 ? ub - 256 : ub;
        sr = mode ? sa - sb : sa + sb;
        p_res  = (mode ? ua - ub : ua + ub) & 255;
        p_cout = mode ? (ua < ub) : (ua + ub > 255);
        p_ovf  = (sr > 127) || (sr < -128);
        m_busy = 1; m_left = W;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy) begin
        chk("result", result, m_res);
        chk("cout", cout, m_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("ovf", ovf_s, m_ovf);
`endif
      end
      if (done) dcount++;
    end
  end
  // call at a negedge; returns at the negedge where done is visible
  task automatic run_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] er, input logic ec, input logic eo, input string nm);
    int n = 0;
    start = 1'b1; mode = m; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); mode = ~m;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, n, W);
    chk({nm, "_result"}, result, er);
    chk({nm, "_cout"}, cout, ec);
`ifdef SERIAL_ADDSUB_OVF_EN
    chk({nm, "_ovf"}, ovf_s, eo);
`else
    if (eo === 1'bx) chk({nm, "_ovf_arg"}, eo, 1'b0);
`endif
  endtask
  initial begin
    int n, d0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("reset_busy", busy, 0);
    chk("reset_result", result, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(1'b0, 8'h3C, 8'h0F, 8'h4B, 1'b0, 1'b0, "add_3c_0f");
    @(negedge clk);
    run_op(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, "add_ff_01");
    @(negedge clk);
    run_op(1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, "sub_05_07");
    @(negedge clk);
    run_op(1'b1, 8'h50, 8'h30, 8'h20, 1'b0, 1'b0, "sub_50_30");
    @(negedge clk);
    run_op(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, "add_7f_01");
    @(negedge clk);
    run_op(1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
    run_op(1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, "b2b_add");
    run_op(1'b1, 8'h34, 8'h12, 8'h22, 1'b0, 1'b0, "b2b_sub");
    @(negedge clk);
    chk("b2b_single_pulse", done, 0);
    // start during RUN is ignored
    d0 = dcount;
    start = 1'b1; mode = 1'b0; a = 8'h10; b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'hAA; b = 8'h55;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ignore_result", result, 8'h20);
    repeat (12) @(negedge clk);
    chk("ignore_done_count", dcount - d0, 1);
    // reset mid-run aborts
    start = 1'b1; mode = 1'b0; a = 8'h11; b = 8'h22;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    d0 = dcount;
    repeat (12) @(negedge clk);
    chk("abort_no_done", dcount - d0, 0);
    run_op(1'b0, 8'hA5, 8'h5A, 8'hFF, 1'b0, 1'b0, "after_abort");
    // random traffic, including starts during RUN and occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      mode  = 1'($urandom);
      a     = 8'($urandom);
      b     = 8'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
